// File: rtl/key_sw_input_unit_if.sv
// Memory-mapped access bundle between the CPU MEM stage and the switch/key peripheral.
// The MEM stage is the master: it drives address and store data and receives read_data.
interface key_sw_input_unit_if #(
    parameter int XLEN = 32
) ();
    logic [XLEN-1:0] address;
    logic            write_enable;
    logic [XLEN-1:0] write_data;
    logic [XLEN-1:0] read_data;

    modport master (
        output address,
        output write_enable,
        output write_data,
        input  read_data
    );

    modport slave (
        input  address,
        input  write_enable,
        input  write_data,
        output read_data
    );
endinterface

// File: rtl/key_sw_input_unit.sv
// Switch and key input peripheral for the data-memory read path.
// Raw board inputs are synchronised, debounced bit by bit, and exposed through
// three word registers: SW level, KEY level and a sticky write-1-to-clear
// key-press capture register (KEYCAP).
module key_sw_input_unit #(
    parameter int XLEN            = 32,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [9:0]           SW,
    input  logic [3:0]           KEY,
    key_sw_input_unit_if.slave   bus,
    output logic [9:0]           sw_level,
    output logic [3:0]           key_level,
    output logic                 key_event
);

    localparam int NUM_IN = 14;

    localparam logic [XLEN-1:0] ADDR_SW     = XLEN'(32'h4000_0100);
    localparam logic [XLEN-1:0] ADDR_KEY    = XLEN'(32'h4000_0200);
    localparam logic [XLEN-1:0] ADDR_KEYCAP = XLEN'(32'h4000_0204);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Inputs packed as {keys, switches}; keys are flipped so 1 means pressed.
    logic [NUM_IN-1:0] rawIn;
    logic [NUM_IN-1:0] meta_q;
    logic [NUM_IN-1:0] sync_q;

    logic [NUM_IN-1:0] level_q;
    logic [NUM_IN-1:0] level_d;
    logic [CNT_W-1:0]  cnt_q [NUM_IN];
    logic [CNT_W-1:0]  cnt_d [NUM_IN];

    logic [3:0] keycap_q;
    logic [3:0] keycap_d;
    logic [3:0] keyPress;
    logic [3:0] capClear;

    logic [XLEN-3:0] addrWord;
    logic            hitSw;
    logic            hitKey;
    logic            hitKeycap;

    logic unusedBits;

    assign rawIn = {~KEY, SW};

    // Two-flop synchroniser for every raw input bit; reset value means switch off, key released.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= rawIn;
            sync_q <= meta_q;
        end
    end

    // Per-bit debounce: a new value is accepted only after it differs from the accepted state for DEBOUNCE_CYCLES evaluations in a row.
    always_comb begin
        level_d = level_q;
        for (int i = 0; i < NUM_IN; i++) begin
            cnt_d[i] = '0;
            if (sync_q[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    level_d[i] = sync_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Accepted levels and debounce counters; reset discards any count in progress.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            level_q <= '0;
            for (int i = 0; i < NUM_IN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            level_q <= level_d;
            for (int i = 0; i < NUM_IN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Word-granular address decode over the full address; the byte offset is ignored.
    assign addrWord  = bus.address[XLEN-1:2];
    assign hitSw     = (addrWord == ADDR_SW[XLEN-1:2]);
    assign hitKey    = (addrWord == ADDR_KEY[XLEN-1:2]);
    assign hitKeycap = (addrWord == ADDR_KEYCAP[XLEN-1:2]);

    // Capture next state: press edges set bits, W1C stores clear bits, and a set beats a clear on the same edge.
    always_comb begin
        keyPress = level_d[13:10] & ~level_q[13:10];
        capClear = 4'h0;
        if (bus.write_enable && hitKeycap) begin
            capClear = bus.write_data[3:0];
        end
        keycap_d = (keycap_q & ~capClear) | keyPress;
    end

    // Sticky key-press capture register polled by software.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            keycap_q <= 4'h0;
        end else begin
            keycap_q <= keycap_d;
        end
    end

    // Combinational read mux so the MEM stage sees data in the same cycle; a same-cycle clear still reads the old capture value.
    always_comb begin
        bus.read_data = '0;
        if (hitSw) begin
            bus.read_data[9:0] = level_q[9:0];
        end else if (hitKey) begin
            bus.read_data[3:0] = level_q[13:10];
        end else if (hitKeycap) begin
            bus.read_data[3:0] = keycap_q;
        end
    end

    assign sw_level  = level_q[9:0];
    assign key_level = level_q[13:10];
    assign key_event = |keycap_q;

    // Store data above the capture field and the byte offset carry no meaning here.
    assign unusedBits = ^{bus.write_data[XLEN-1:4], bus.address[1:0]};

endmodule

// File: tb/tb_key_sw_input_unit.sv
// Self-checking bench for key_sw_input_unit with a short debounce window.
// Directed steps walk through reset, clean press, bounce, W1C, set-vs-clear and
// decode cases, then a randomized phase is checked against a sliding-window model.
module tb_key_sw_input_unit;

   localparam int D = 4;

   localparam logic [31:0] ADDR_SW     = 32'h4000_0100;
   localparam logic [31:0] ADDR_KEY    = 32'h4000_0200;
   localparam logic [31:0] ADDR_KEYCAP = 32'h4000_0204;

   logic       clock;
   logic       reset;
   logic [9:0] SW;
   logic [3:0] KEY;
   logic [9:0] sw_level;
   logic [3:0] key_level;
   logic       key_event;

   int testCount = 0;
   int failCount = 0;

   key_sw_input_unit_if #(.XLEN(32)) busIf ();

   key_sw_input_unit #(
      .XLEN(32),
      .DEBOUNCE_CYCLES(D)
   ) dut (
      .clock(clock),
      .reset(reset),
      .SW(SW),
      .KEY(KEY),
      .bus(busIf),
      .sw_level(sw_level),
      .key_level(key_level),
      .key_event(key_event)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Reference model state: raw-sample pipe, window of evaluated samples, accepted levels, capture bits.
   logic [13:0] mRawQ[$];
   logic [13:0] mSHist[$];
   logic [13:0] mLevel;
   logic [3:0]  mCap;

   // Model: a bit flips once its synchronised sample has disagreed with the accepted level for the last D edges.
   always @(posedge clock or posedge reset) begin
      logic [13:0] s;
      logic [13:0] newLevel;
      logic [3:0]  press;
      logic [3:0]  clr;
      bit          allFlip;
      if (reset) begin
         mRawQ.delete();
         mRawQ.push_back(14'h0);
         mRawQ.push_back(14'h0);
         mSHist.delete();
         mLevel = '0;
         mCap   = '0;
      end else begin
         s = mRawQ[0];
         mRawQ.push_back({~KEY, SW});
         void'(mRawQ.pop_front());
         mSHist.push_back(s);
         if (mSHist.size() > D) void'(mSHist.pop_front());
         newLevel = mLevel;
         if (mSHist.size() == D) begin
            for (int b = 0; b < 14; b++) begin
               allFlip = 1'b1;
               for (int k = 0; k < D; k++) begin
                  if (mSHist[k][b] == mLevel[b]) allFlip = 1'b0;
               end
               if (allFlip) newLevel[b] = ~mLevel[b];
            end
         end
         press = newLevel[13:10] & ~mLevel[13:10];
         clr = 4'h0;
         if (busIf.write_enable && ({busIf.address[31:2], 2'b00} == ADDR_KEYCAP)) clr = busIf.write_data[3:0];
         mCap   = (mCap & ~clr) | press;
         mLevel = newLevel;
      end
   end

   // Expected register read for an address under the current model state.
   function automatic logic [31:0] expRead(input logic [31:0] addr);
      logic [31:0] word;
      word = {addr[31:2], 2'b00};
      if (word == ADDR_SW)     return {22'h0, mLevel[9:0]};
      if (word == ADDR_KEY)    return {28'h0, mLevel[13:10]};
      if (word == ADDR_KEYCAP) return {28'h0, mCap};
      return 32'h0;
   endfunction

   // Drive every DUT input at once.
   task automatic applyStimulus(input logic [9:0] sw, input logic [3:0] key, input logic [31:0] addr,
                                input logic we, input logic [31:0] wd);
      SW                  = sw;
      KEY                 = key;
      busIf.address       = addr;
      busIf.write_enable  = we;
      busIf.write_data    = wd;
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clock);
   endtask

   // Compare one observed value against a bench-derived expectation.
   task automatic checkConst(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Compare all DUT outputs against the reference model.
   task automatic checkOutput(input string tag);
      checkConst({tag, " sw_level"},  {22'h0, sw_level},  {22'h0, mLevel[9:0]});
      checkConst({tag, " key_level"}, {28'h0, key_level}, {28'h0, mLevel[13:10]});
      checkConst({tag, " key_event"}, {31'h0, key_event}, {31'h0, |mCap});
      checkConst({tag, " read_data"}, busIf.read_data,    expRead(busIf.address));
   endtask

   logic [3:0]  bouncePat [14];
   logic [31:0] randAddr  [6];

   initial begin
      logic [9:0]  curSw;
      logic [3:0]  curKey;
      logic [31:0] addr;
      int          r;

      reset = 1'b1;
      applyStimulus(10'h0, 4'hF, ADDR_KEYCAP, 1'b0, 32'h0);
      waitCycles(2);
      reset = 1'b0;

      // Step 1: levels set, then asynchronous reset mid-cycle, then re-acceptance.
      applyStimulus(10'h3FF, 4'h0, ADDR_KEYCAP, 1'b0, 32'h0);
      waitCycles(8);
      checkOutput("pre-reset");
      checkConst("pre-reset sw_level", {22'h0, sw_level}, 32'h3FF);
      #2 reset = 1'b1;
      #1;
      checkConst("reset sw_level",  {22'h0, sw_level},  32'h0);
      checkConst("reset key_level", {28'h0, key_level}, 32'h0);
      checkConst("reset key_event", {31'h0, key_event}, 32'h0);
      checkConst("reset read_data", busIf.read_data,    32'h0);
      @(negedge clock);
      reset = 1'b0;
      waitCycles(5);
      checkConst("post-reset edge5 sw_level",  {22'h0, sw_level},  32'h0);
      checkConst("post-reset edge5 key_level", {28'h0, key_level}, 32'h0);
      waitCycles(1);
      checkConst("post-reset edge6 sw_level",  {22'h0, sw_level},  32'h3FF);
      checkConst("post-reset edge6 key_level", {28'h0, key_level}, 32'hF);
      checkConst("post-reset keycap",          busIf.read_data,    32'hF);
      checkConst("post-reset key_event",       {31'h0, key_event}, 32'h1);
      checkOutput("post-reset");

      // Step 2: clean press of KEY[2].
      applyStimulus(10'h0, 4'hF, ADDR_KEYCAP, 1'b0, 32'h0);
      waitCycles(8);
      applyStimulus(10'h0, 4'hF, ADDR_KEYCAP, 1'b1, 32'hF);
      waitCycles(1);
      applyStimulus(10'h0, 4'hF, ADDR_KEYCAP, 1'b0, 32'h0);
      #1 checkConst("cleared keycap", busIf.read_data, 32'h0);
      applyStimulus(10'h0, 4'b1011, ADDR_KEYCAP, 1'b0, 32'h0);
      waitCycles(5);
      checkConst("press edge5 key_level", {28'h0, key_level}, 32'h0);
      waitCycles(1);
      checkConst("press edge6 key_level", {28'h0, key_level}, 32'h4);
      checkConst("press keycap",          busIf.read_data,    32'h4);
      checkOutput("press");

      // Step 3: bounce on KEY[0] never gets accepted.
      applyStimulus(10'h0, 4'b1011, ADDR_KEYCAP, 1'b1, 32'h4);
      waitCycles(1);
      bouncePat = '{4'b1010, 4'b1010, 4'b1010, 4'b1011, 4'b1010, 4'b1010, 4'b1010,
                    4'b1011, 4'b1011, 4'b1011, 4'b1011, 4'b1011, 4'b1011, 4'b1011};
      for (int i = 0; i < 14; i++) begin
         applyStimulus(10'h0, bouncePat[i], ADDR_KEYCAP, 1'b0, 32'h0);
         waitCycles(1);
         checkConst("bounce key_level0", {31'h0, key_level[0]}, 32'h0);
         checkOutput("bounce");
      end
      checkConst("bounce keycap", busIf.read_data, 32'h0);

      // Step 4: W1C clears selected bits; a write to the KEY register is ignored.
      applyStimulus(10'h0, 4'hF, ADDR_KEYCAP, 1'b0, 32'h0);
      waitCycles(8);
      applyStimulus(10'h0, 4'h0, ADDR_KEYCAP, 1'b0, 32'h0);
      waitCycles(8);
      checkConst("all pressed keycap", busIf.read_data, 32'hF);
      applyStimulus(10'h0, 4'h0, ADDR_KEYCAP, 1'b1, 32'h5);
      #1 checkConst("w1c same-cycle read", busIf.read_data, 32'hF);
      waitCycles(1);
      applyStimulus(10'h0, 4'h0, ADDR_KEYCAP, 1'b0, 32'h0);
      #1 checkConst("w1c next read", busIf.read_data, 32'hA);
      applyStimulus(10'h0, 4'h0, ADDR_KEY, 1'b1, 32'hF);
      #1 checkConst("key reg during write", busIf.read_data, 32'hF);
      waitCycles(1);
      applyStimulus(10'h0, 4'h0, ADDR_KEYCAP, 1'b0, 32'h0);
      #1 checkConst("ro write ignored", busIf.read_data, 32'hA);
      checkOutput("w1c");

      // Step 5: press acceptance and W1C of the same bit on one edge; the set wins.
      applyStimulus(10'h0, 4'b0010, ADDR_KEYCAP, 1'b0, 32'h0);
      waitCycles(8);
      checkConst("release keeps keycap", busIf.read_data, 32'hA);
      applyStimulus(10'h0, 4'b0010, ADDR_KEYCAP, 1'b1, 32'h2);
      waitCycles(1);
      applyStimulus(10'h0, 4'b0010, ADDR_KEYCAP, 1'b0, 32'h0);
      #1 checkConst("bit1 cleared", busIf.read_data, 32'h8);
      applyStimulus(10'h0, 4'h0, ADDR_KEYCAP, 1'b0, 32'h0);
      waitCycles(5);
      checkConst("set-vs-clear pre key_level", {28'h0, key_level}, 32'hD);
      checkConst("set-vs-clear pre keycap",    busIf.read_data,    32'h8);
      applyStimulus(10'h0, 4'h0, ADDR_KEYCAP, 1'b1, 32'h2);
      waitCycles(1);
      applyStimulus(10'h0, 4'h0, ADDR_KEYCAP, 1'b0, 32'h0);
      #1;
      checkConst("set-vs-clear key_level", {28'h0, key_level}, 32'hF);
      checkConst("set-vs-clear keycap",    busIf.read_data,    32'hA);

      // Step 6: address decode.
      applyStimulus(10'h2A5, 4'h0, ADDR_SW, 1'b0, 32'h0);
      waitCycles(8);
      #1 checkConst("decode 0x40000100", busIf.read_data, 32'h2A5);
      applyStimulus(10'h2A5, 4'h0, 32'h4000_0103, 1'b0, 32'h0);
      #1 checkConst("decode 0x40000103", busIf.read_data, 32'h2A5);
      applyStimulus(10'h2A5, 4'h0, 32'h4000_0300, 1'b0, 32'h0);
      #1 checkConst("decode 0x40000300", busIf.read_data, 32'h0);
      applyStimulus(10'h2A5, 4'h0, 32'h1000_0100, 1'b0, 32'h0);
      #1 checkConst("decode 0x10000100", busIf.read_data, 32'h0);
      waitCycles(1);

      // Randomized phase: sparse bit flips, mixed reads and writes, one mid-run reset.
      randAddr = '{ADDR_SW, ADDR_KEY, ADDR_KEYCAP, 32'h4000_0103, 32'h4000_0205, 32'h0};
      curSw  = 10'h2A5;
      curKey = 4'h0;
      for (int i = 0; i < 400; i++) begin
         r = int'($urandom_range(0, 7));
         if (r == 0) curSw[$urandom_range(0, 9)] = ~curSw[$urandom_range(0, 9)];
         if (r == 1) curKey = curKey ^ (4'h1 << $urandom_range(0, 3));
         if (r == 2) curSw = curSw ^ (10'h1 << $urandom_range(0, 9));
         addr = randAddr[$urandom_range(0, 5)];
         if (addr == 32'h0) addr = $urandom;
         applyStimulus(curSw, curKey, addr, ($urandom_range(0, 5) == 0), $urandom);
         #1 checkOutput("random");
         if (i == 200) begin
            #1 reset = 1'b1;
            #1 checkOutput("random reset");
         end
         @(negedge clock);
         reset = 1'b0;
      end

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
